// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the write-back arbiter
package wb_pkg;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int NUM_WB_PORTS = 2;
  localparam int NUM_REGS     = 1 << ADDR_W;

  // Port indices into the per-port arrays
  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // One-hot of a register index, used to build the pending mask
  function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [ADDR_W-1:0] d);
    dest_onehot    = '0;
    dest_onehot[d] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// rtl/wb_slot.sv - one-entry holding slot with valid/ready input and clear strobe
module wb_slot
  import wb_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    valid_i,
  input  wb_req_t req_i,
  output logic    ready_o,
  input  logic    clear_i,
  output logic    full_o,
  output wb_req_t req_o
);

  logic    full_q, full_d;
  wb_req_t req_q, req_d;

  // Ready depends only on occupancy, so a slot never accepts and drains on the same edge
  assign ready_o = ~full_q;
  assign full_o  = full_q;
  assign req_o   = req_q;

  // Next-state: clear only happens while full, capture only while empty
  always_comb begin
    full_d = full_q;
    req_d  = req_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (valid_i && !full_q) begin
      full_d = 1'b1;
      req_d  = req_i;
    end
  end

  // Slot state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else begin
      full_q <= full_d;
      req_q  <= req_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin arbiter for the register file write port
module wb_arbiter
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wbWindow,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_dest,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_dest,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  output logic                regWrite,
  output logic [ADDR_W-1:0]   wbDestination,
  output logic [DATA_W-1:0]   WBDATA,
  output logic [NUM_REGS-1:0] pending_mask
);

  logic [NUM_WB_PORTS-1:0] in_valid, in_ready, full, grant;
  wb_req_t                 slot_in  [NUM_WB_PORTS];
  wb_req_t                 slot_out [NUM_WB_PORTS];
  wb_req_t                 sel;

  logic              last_grant_q, last_grant_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  assign in_valid[WB_ALU]  = req0_valid;
  assign in_valid[WB_LOAD] = req1_valid;
  assign slot_in[WB_ALU]   = '{dest: req0_dest, data: req0_data};
  assign slot_in[WB_LOAD]  = '{dest: req1_dest, data: req1_data};
  assign req0_ready        = in_ready[WB_ALU];
  assign req1_ready        = in_ready[WB_LOAD];

  for (genvar p = 0; p < NUM_WB_PORTS; p++) begin : g_slot
    wb_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (in_valid[p]),
      .req_i   (slot_in[p]),
      .ready_o (in_ready[p]),
      .clear_i (grant[p]),
      .full_o  (full[p]),
      .req_o   (slot_out[p])
    );
  end

  // Grant: single full slot wins outright; a tie goes to the port not granted last
  always_comb begin
    grant = '0;
    if (wbWindow) begin
      if (full[WB_ALU] && full[WB_LOAD]) begin
        if (last_grant_q) grant[WB_ALU]  = 1'b1;
        else              grant[WB_LOAD] = 1'b1;
      end else begin
        grant = full;
      end
    end
  end

  assign sel = grant[WB_LOAD] ? slot_out[WB_LOAD] : slot_out[WB_ALU];

  // Output stage next-state: dest 0 is consumed but never written
  always_comb begin
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    wb_dest_d    = wb_dest_q;
    wb_data_d    = wb_data_q;
    if (|grant) begin
      last_grant_d = grant[WB_LOAD];
      if (sel.dest != '0) begin
        reg_write_d = 1'b1;
        wb_dest_d   = sel.dest;
        wb_data_d   = sel.data;
      end
    end
  end

  // Arbitration and output stage registers; last_grant resets so port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      reg_write_q  <= 1'b0;
      wb_dest_q    <= '0;
      wb_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      wb_dest_q    <= wb_dest_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign regWrite      = reg_write_q;
  assign wbDestination = wb_dest_q;
  assign WBDATA        = wb_data_q;

  // Pending mask: every held destination plus the one on the output stage, never r0
  always_comb begin
    pending_mask = '0;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      if (full[p]) pending_mask |= dest_onehot(slot_out[p].dest);
    end
    if (reg_write_q) pending_mask |= dest_onehot(wb_dest_q);
    pending_mask[0] = 1'b0;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the 32x32 register file write port. Two producers, ALU write-back (port 0) and load write-back (port 1), each hand over a (destination, data) pair through a valid/ready handshake into a private one-entry holding slot. The arbiter grants the single write port round-robin, only while the write window is open, and drives `regWrite` / `wbDestination` / `WBDATA` straight into the register file. A pending-destination mask lets decode stall on in-flight writes.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register index width

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `wbWindow`  in  1  register file write window open (1 = writes permitted)
- `req0_valid`  in  1  ALU write-back request
- `req0_dest`  in  ADDR_W  ALU destination register
- `req0_data`  in  DATA_W  ALU result
- `req0_ready`  out  1  port 0 slot empty
- `req1_valid`, `req1_dest`, `req1_data`, `req1_ready`: same as port 0, for load write-back
- `regWrite`  out  1  register file write enable, registered
- `wbDestination`  out  ADDR_W  register file write index, registered
- `WBDATA`  out  DATA_W  register file write data, registered
- `pending_mask`  out  32  bit r set while register r is held in a slot or on the output stage

## Operation
- Each port has a slot (`full`, `dest`, `data`).
  - `reqN_ready = ~fullN` (combinational).
  - Transfer happens when `valid && ready` at a rising edge; the slot captures `dest`/`data` and sets `full`.
  - `valid` held with `ready` low has no effect. Requesters must hold `dest` and `data` stable until the transfer.
- Grant, evaluated each edge, only when `wbWindow=1`:
  - Neither slot full: no grant.
  - One slot full: grant that slot.
  - Both slots full: grant the port not in `last_grant`.
  - `last_grant` updates to the granted port.
  - Granted slot clears at the same edge.
- Output stage, at each edge:
  - Grant with dest≠0: `regWrite<=1`, `wbDestination<=dest`, `WBDATA<=data`.
  - Otherwise: `regWrite<=0`; `wbDestination` and `WBDATA` hold their previous values.
- Dest 0: consumed normally (slot clears, `last_grant` updates) but never asserts `regWrite`.
- `wbWindow=0`: no grants, slots hold, `regWrite<=0` at the next edge. A write already on the output stage completes in its current cycle.
- `pending_mask`: OR of the one-hot of each full slot's dest and, when `regWrite=1`, the one-hot of `wbDestination`. Bit 0 is never set. Both slots may hold the same dest; arbitration order then decides the final value.
- Reset mid-operation: slot contents are discarded and the output stage is cancelled immediately (asynchronous).

## Timing
- Reset values:
  - `full0 = full1 = 0`, so both `ready`s are 1.
  - `regWrite=0`, `wbDestination=0`, `WBDATA=0`, `pending_mask=0`.
  - `last_grant=1`, so port 0 wins the first tie.
- Latency, with the window open:
  - Transfer at edge N → grant at edge N+1 → `regWrite` high during cycle N+1..N+2 → register file writes at edge N+2.
  - `reqN_ready` returns high after edge N+1.
- Throughput:
  - Per port: one write every 2 cycles (no same-edge accept and drain).
  - Aggregate: one write per cycle while both slots stay busy.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.
- `regWrite` is never high for two cycles carrying the same slot entry.

## Structure
- Package `wb_pkg`:
  - `DATA_W=32`, `ADDR_W=5`, `NUM_WB_PORTS=2`.
  - `wb_req_t` struct: `dest`, `data`.
  - Port index constants `WB_ALU=0`, `WB_LOAD=1`.
- Sub-module `wb_slot`: one-entry holding slot with valid/ready in and a clear strobe; instantiated once per port. Arbitration, output stage and mask generation live in `wb_arbiter`.

## Test plan
- Reset: assert `rst_n=0` mid-traffic with both slots full.
  - Required: `req0_ready=req1_ready=1`, `regWrite=0`, `pending_mask=0` immediately; no write after release.
- Single write: port 0 sends dest 7, data 0xDEADBEEF at edge N, window open.
  - Required: `pending_mask[7]=1` from N; `regWrite=1`, `wbDestination=7`, `WBDATA=0xDEADBEEF` for exactly one cycle after N+1; mask clear after N+2.
- Contention: both ports fill on the same edge (port 0 dest 3, port 1 dest 4); 10 further back-to-back requests per port.
  - Required: first write is to 3, then writes alternate ports every cycle; no request lost; order within each port preserved.
- Window closed: slots filled with `wbWindow=0` for 20 cycles.
  - Required: `regWrite` stays 0 and both `ready`s stay low; within 2 cycles of the window opening, writes drain port 0 then port 1.
- Dest 0: port 1 sends dest 0, data 0x55.
  - Required: slot clears after one grant edge; `regWrite` stays 0; `pending_mask` never nonzero; the next tie goes to port 0.
- Same dest: port 0 dest 9 data 1, port 1 dest 9 data 2, filled simultaneously.
  - Required: writes occur in order 1 then 2; `pending_mask[9]` holds until the second write completes.
